// File: rtl/perm_register_file.sv
// Parametrised permutation register file: DEPTH x WIDTH registers with init, swap,
// write, rotate and a multi-cycle range-reverse sequencer behind a valid/ready port.
module perm_register_file #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [AW-1:0]          cmd_x,
  input  logic [AW-1:0]          cmd_y,
  input  logic [WIDTH-1:0]       cmd_data,
  output logic [WIDTH-1:0]       rd_x_data,
  output logic [WIDTH-1:0]       rd_y_data,
  output logic [DEPTH*WIDTH-1:0] regs_flat,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic {
    S_IDLE,
    S_REV
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_INIT    = 3'd1,
    OP_SWAP    = 3'd2,
    OP_WRITE   = 3'd3,
    OP_ROT_L   = 3'd4,
    OP_ROT_R   = 3'd5,
    OP_REVERSE = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [AW-1:0]    lo_q, lo_d, hi_q, hi_d;
  logic             done_q, done_d, err_q, err_d;

  logic             accept, x_ok, y_ok, bad_cmd, rev_start, rev_last;
  logic [AW-1:0]    rev_next_lo, rev_next_hi;
  op_e              op;

  function automatic logic [WIDTH-1:0] init_val(input int unsigned i);
    return WIDTH'(i);
  endfunction

  // Command decode shared by the next-state and datapath logic
  always_comb begin
    op          = op_e'(cmd_op);
    accept      = cmd_valid && cmd_ready;
    x_ok        = {1'b0, cmd_x} < DEPTH_W;
    y_ok        = {1'b0, cmd_y} < DEPTH_W;
    bad_cmd     = 1'b0;
    case (op)
      OP_RSVD:             bad_cmd = 1'b1;
      OP_WRITE:            bad_cmd = !x_ok;
      OP_SWAP, OP_REVERSE: bad_cmd = !(x_ok && y_ok);
      default:             bad_cmd = 1'b0;
    endcase
    rev_start   = accept && !bad_cmd && (op == OP_REVERSE) && (cmd_x != cmd_y);
    rev_next_lo = lo_q + AW'(1);
    rev_next_hi = hi_q - AW'(1);
    rev_last    = rev_next_lo >= rev_next_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= init_val(i);
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      S_IDLE: begin
        if (rev_start) begin
          state_d = S_REV;
          lo_d    = (cmd_x < cmd_y) ? cmd_x : cmd_y;
          hi_d    = (cmd_x < cmd_y) ? cmd_y : cmd_x;
        end
      end
      S_REV: begin
        lo_d = rev_next_lo;
        hi_d = rev_next_hi;
        if (rev_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array update: one swap per cycle while reversing, otherwise the accepted command
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    done_d = 1'b0;
    err_d  = 1'b0;
    if (state_q == S_REV) begin
      regs_d[lo_q] = regs_q[hi_q];
      regs_d[hi_q] = regs_q[lo_q];
      done_d       = rev_last;
    end else if (accept) begin
      if (bad_cmd) begin
        err_d = 1'b1;
      end else begin
        done_d = !rev_start;
        case (op)
          OP_INIT: begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_d[i] = init_val(i);
          end
          OP_SWAP: begin
            regs_d[cmd_x] = regs_q[cmd_y];
            regs_d[cmd_y] = regs_q[cmd_x];
          end
          OP_WRITE: regs_d[cmd_x] = cmd_data;
          OP_ROT_L: begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_d[i] = regs_q[(i + 1) % DEPTH];
          end
          OP_ROT_R: begin
            for (int unsigned i = 0; i < DEPTH; i++)
              regs_d[i] = regs_q[(i + DEPTH - 1) % DEPTH];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q == S_REV);
    done      = done_q;
    err       = err_q;
    rd_x_data = x_ok ? regs_q[cmd_x] : '0;
    rd_y_data = y_ok ? regs_q[cmd_y] : '0;
    regs_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
  end

endmodule

// File: doc/perm_register_file.md
Name: perm_register_file

Overview:
- Parametrised successor to the team's 8x4 swap register file.
- DEPTH registers of WIDTH bits. Supports init-to-index, single-cycle swap, write, and rotate-left/right operations.
- Also supports a multi-cycle range-reverse sequencer.
- Commands arrive over a valid/ready handshake. The whole array is exposed flattened for downstream sorting/permutation datapaths.

Parameters:
- WIDTH, 4, bits per register (≥1)
- DEPTH, 8, number of registers (≥2, need not be a power of 2); index width AW = clog2(DEPTH) derived internally

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  0 NOP, 1 INIT, 2 SWAP, 3 WRITE, 4 ROT_L, 5 ROT_R, 6 REVERSE, 7 reserved
- cmd_x  in  AW  first index
- cmd_y  in  AW  second index
- cmd_data  in  WIDTH  write data for WRITE
- rd_x_data  out  WIDTH  combinational r[cmd_x]; 0 if cmd_x ≥ DEPTH
- rd_y_data  out  WIDTH  combinational r[cmd_y]; 0 if cmd_y ≥ DEPTH
- regs_flat  out  DEPTH*WIDTH  r[i] at bits [i*WIDTH +: WIDTH]
- busy  out  1  REVERSE sequence in progress
- done  out  1  one-cycle pulse, registered, after a command completes
- err  out  1  one-cycle pulse, registered, after a rejected command

Behaviour:
- Reset (rst_n=0 at an edge):
  - r[i] = i mod 2^WIDTH; state IDLE; busy 0; done 0; err 0; cmd_ready 1.
  - Reset mid-REVERSE aborts the sequence and overrides any command in the same cycle.
- Handshake:
  - A command is accepted at an edge where cmd_valid && cmd_ready.
  - cmd_ready = !busy (combinational from state).
  - Inputs are ignored when not accepted.
- Single-cycle ops take effect at the accepting edge. done=1 for exactly the following cycle.
  - NOP: no change; done pulses.
  - INIT: r[i] = i mod 2^WIDTH.
  - SWAP: r[x]<=r[y] and r[y]<=r[x] simultaneously; x==y leaves the array unchanged.
  - WRITE: r[x]<=cmd_data.
  - ROT_L: r[i]<=r[(i+1) mod DEPTH].
  - ROT_R: r[i]<=r[(i-1+DEPTH) mod DEPTH].
- REVERSE (range reverse of r[lo..hi], lo=min(x,y), hi=max(x,y)):
  - x==y: behaves as NOP; done pulses; busy stays 0.
  - Otherwise, the accepting edge latches lo/hi and moves IDLE→REV with no swap; busy=1 from the next cycle.
  - Each subsequent edge in REV swaps r[lo]/r[hi], then lo+1 and hi-1.
  - When the new lo ≥ new hi: return to IDLE, busy 0, done 1 for one cycle.
  - Busy duration = floor((hi-lo+1)/2) cycles.
  - Commands presented while busy are not accepted and must be held by the source.
- Errors:
  - Rejected conditions: op 7; any used index ≥ DEPTH (x for WRITE; x and y for SWAP and REVERSE).
  - On rejection: array unchanged, err=1 for one cycle after the edge, done stays 0, state stays IDLE.
- done and err are never high together. Both are 0 in any cycle not directly following a completion or rejection.
- regs_flat and busy are registered state. No combinational path from cmd_* to regs_flat.

Test Plan:
- Reset, then ROT_L, then ROT_R (DEPTH=8, WIDTH=4):
  - Hold rst_n=0 for 2 cycles, release → regs_flat = r0..r7 = 0..7, cmd_ready=1, busy=0, done=0, err=0.
  - ROT_L → r = 1,2,3,4,5,6,7,0; done high one cycle.
  - ROT_R → r = 0..7 again.
- Swap chain: SWAP(0,7), SWAP(1,6), SWAP(2,5), SWAP(3,4), issued back-to-back with cmd_valid held 4 cycles → r = 7,6,5,4,3,2,1,0; done high 4 consecutive cycles.
- Full REVERSE from init: REVERSE(7,0) → busy high exactly 4 cycles; cmd_ready low during those cycles; r = 7..0; single done pulse after busy falls. A WRITE held during busy is accepted only on the first cycle with cmd_ready=1.
- Odd range: INIT, then REVERSE(2,6) → busy 2 cycles; r = 0,1,6,5,4,3,2,7. REVERSE(3,3) → done, busy never high, no change.
- Errors, DEPTH=6 build:
  - SWAP(1,6) → err one cycle; r unchanged = 0..5; done 0.
  - op 7 → err.
  - WRITE(5, 4'hA) → r5=A; rd_x_data with cmd_x=5 reads A.
- Reset mid-REVERSE: REVERSE(0,7), drop rst_n after 2 busy cycles → next cycle r = 0..7, busy=0, no done pulse, cmd_ready=1.
